// File: rtl/writeback_arbiter.sv
// writeback_arbiter: owns the register file write port. Merges never-stalled
// ALU results with handshaked mult/div results. Mult/div results that lose
// arbitration wait in a small in-order FIFO. A pending scoreboard tracks
// mult/div destinations that have not been written back yet.
module writeback_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     ctrl_reset,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [31:0]              alu_data,
   input  logic                     md_valid,
   output logic                     md_ready,
   input  logic [4:0]               md_rd,
   input  logic [31:0]              md_data,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_rd,
   output logic [31:0]              pending_mask,
   output logic                     ctrl_writeEnable,
   output logic [4:0]               ctrl_writeReg,
   output logic [31:0]              data_writeReg,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [4:0]    rd_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;

   logic          fifo_empty;
   logic          md_accept;
   logic          push;
   logic          pop;
   logic          sel_valid;
   logic          sel_md;
   logic [4:0]    sel_rd;
   logic [31:0]   sel_data;
   logic [31:0]   clear_mask;
   logic [31:0]   set_mask;

   // Ready comes purely from the registered occupancy, so there is no
   // combinational path from md_valid back to md_ready.
   assign md_ready   = (fifo_count < FULL_COUNT);
   assign fifo_empty = (fifo_count == '0);
   assign md_accept  = md_valid && md_ready;

   // Pick the source for this edge: ALU first, then the FIFO head, then a
   // freshly accepted mult/div result going straight through an empty FIFO.
   always_comb begin
      sel_valid = 1'b0;
      sel_md    = 1'b0;
      sel_rd    = 5'd0;
      sel_data  = 32'd0;
      pop       = 1'b0;
      push      = md_accept;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel_md    = 1'b1;
         sel_rd    = rd_mem[head];
         sel_data  = data_mem[head];
         pop       = 1'b1;
      end else if (md_accept) begin
         sel_valid = 1'b1;
         sel_md    = 1'b1;
         sel_rd    = md_rd;
         sel_data  = md_data;
         push      = 1'b0;
      end
   end

   // Scoreboard masks: a mult/div write clears its bit, an issue sets one.
   // Applying the set after the clear makes set win on the same register.
   always_comb begin
      clear_mask = 32'd0;
      set_mask   = 32'd0;
      if (sel_md) begin
         clear_mask = 32'd1 << sel_rd;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         set_mask = 32'd1 << issue_rd;
      end
   end

   // FIFO storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (push) begin
         rd_mem[tail]   <= md_rd;
         data_mem[tail] <= md_data;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         head       <= '0;
         tail       <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            tail <= tail + AW'(1);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + (AW+1)'(1);
         end else if (pop && !push) begin
            fifo_count <= fifo_count - (AW+1)'(1);
         end
      end
   end

   // Registered write port; writes to r0 are consumed but never enabled,
   // and address/data hold their last value when nothing is selected.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= 5'd0;
         data_writeReg    <= 32'd0;
      end else if (sel_valid) begin
         ctrl_writeEnable <= (sel_rd != 5'd0);
         ctrl_writeReg    <= sel_rd;
         data_writeReg    <= sel_data;
      end else begin
         ctrl_writeEnable <= 1'b0;
      end
   end

   // Pending scoreboard update.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         pending_mask <= 32'd0;
      end else begin
         pending_mask <= (pending_mask & ~clear_mask) | set_mask;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed stimulus for the writeback arbiter, checked
// every cycle against a queue-based model and pinned with literal expectations.
module tb_writeback_arbiter;

   localparam int DEPTH = 2;

   logic          clock;
   logic          ctrl_reset;
   logic          alu_valid;
   logic [4:0]    alu_rd;
   logic [31:0]   alu_data;
   logic          md_valid;
   logic          md_ready;
   logic [4:0]    md_rd;
   logic [31:0]   md_data;
   logic          issue_valid;
   logic [4:0]    issue_rd;
   logic [31:0]   pending_mask;
   logic          ctrl_writeEnable;
   logic [4:0]    ctrl_writeReg;
   logic [31:0]   data_writeReg;
   logic [1:0]    fifo_count;

   int checks = 0;
   int passes = 0;
   bit started = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } md_entry_t;

   md_entry_t   model_q[$];
   logic        exp_we;
   logic [4:0]  exp_reg;
   logic [31:0] exp_data;
   logic [31:0] exp_mask;

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .alu_valid        (alu_valid),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .md_valid         (md_valid),
      .md_ready         (md_ready),
      .md_rd            (md_rd),
      .md_data          (md_data),
      .issue_valid      (issue_valid),
      .issue_rd         (issue_rd),
      .pending_mask     (pending_mask),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .fifo_count       (fifo_count)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: accepted results join an in-order queue, and each edge
   // writes the ALU if present, otherwise the oldest queued mult/div result.
   always @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         model_q.delete();
         exp_we   = 1'b0;
         exp_reg  = 5'd0;
         exp_data = 32'd0;
         exp_mask = 32'd0;
      end else begin
         md_entry_t e;
         logic [31:0] clr;
         clr = 32'd0;
         if (md_valid && (model_q.size() < DEPTH)) begin
            model_q.push_back({md_rd, md_data});
         end
         if (alu_valid) begin
            exp_we   = (alu_rd != 0);
            exp_reg  = alu_rd;
            exp_data = alu_data;
         end else if (model_q.size() > 0) begin
            e        = model_q.pop_front();
            exp_we   = (e.rd != 0);
            exp_reg  = e.rd;
            exp_data = e.data;
            clr[e.rd] = 1'b1;
         end else begin
            exp_we = 1'b0;
         end
         exp_mask = exp_mask & ~clr;
         if (issue_valid && issue_rd != 0) begin
            exp_mask[issue_rd] = 1'b1;
         end
      end
   end

   // Every cycle, away from the active edge, compare all outputs to the model.
   always @(negedge clock) begin
      if (started) begin
         checkOutput("writeEnable", 32'(ctrl_writeEnable), 32'(exp_we));
         checkOutput("writeReg", 32'(ctrl_writeReg), 32'(exp_reg));
         checkOutput("writeData", data_writeReg, exp_data);
         checkOutput("pendingMask", pending_mask, exp_mask);
         checkOutput("fifoCount", 32'(fifo_count), 32'(model_q.size()));
         checkOutput("mdReady", 32'(md_ready), 32'(model_q.size() < DEPTH));
      end
   end

   // Drive one cycle of inputs (caller sits just after a falling edge), then
   // wait until the next falling edge so the resulting write is visible.
   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic iv, input logic [4:0] ird);
      alu_valid   = av;
      alu_rd      = ard;
      alu_data    = ad;
      md_valid    = mv;
      md_rd       = mrd;
      md_data     = md;
      issue_valid = iv;
      issue_rd    = ird;
      @(negedge clock);
   endtask

   task automatic idle();
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
   endtask

   initial begin
      ctrl_reset  = 1'b1;
      alu_valid   = 1'b0;
      alu_rd      = 5'd0;
      alu_data    = 32'd0;
      md_valid    = 1'b0;
      md_rd       = 5'd0;
      md_data     = 32'd0;
      issue_valid = 1'b0;
      issue_rd    = 5'd0;
      repeat (2) @(negedge clock);
      ctrl_reset = 1'b0;
      started = 1;
      @(negedge clock);

      // Reset state
      checkOutput("resetWe", 32'(ctrl_writeEnable), 32'd0);
      checkOutput("resetCount", 32'(fifo_count), 32'd0);
      checkOutput("resetReady", 32'(md_ready), 32'd1);

      // ALU-only write, then an idle cycle holding address and data
      applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0);
      checkOutput("aluWe", 32'(ctrl_writeEnable), 32'd1);
      checkOutput("aluReg", 32'(ctrl_writeReg), 32'd5);
      checkOutput("aluData", data_writeReg, 32'hDEADBEEF);
      idle();
      checkOutput("idleWe", 32'(ctrl_writeEnable), 32'd0);
      checkOutput("idleHoldReg", 32'(ctrl_writeReg), 32'd5);
      checkOutput("idleHoldData", data_writeReg, 32'hDEADBEEF);

      // Issue r7, then its result bypasses with the ALU idle
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
      checkOutput("pend7Set", 32'(pending_mask[7]), 32'd1);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd7, 32'h42, 0, 5'd0);
      checkOutput("md7We", 32'(ctrl_writeEnable), 32'd1);
      checkOutput("md7Reg", 32'(ctrl_writeReg), 32'd7);
      checkOutput("md7Data", data_writeReg, 32'h42);
      checkOutput("pend7Clear", 32'(pending_mask[7]), 32'd0);
      checkOutput("md7Count", 32'(fifo_count), 32'd0);

      // ALU busy three cycles while r9, r10, r11 are offered
      applyStimulus(1, 5'd1, 32'h11, 1, 5'd9, 32'h900, 0, 5'd0);
      checkOutput("collideCount1", 32'(fifo_count), 32'd1);
      applyStimulus(1, 5'd2, 32'h22, 1, 5'd10, 32'hA00, 0, 5'd0);
      checkOutput("collideCount2", 32'(fifo_count), 32'd2);
      checkOutput("collideReady0", 32'(md_ready), 32'd0);
      applyStimulus(1, 5'd3, 32'h33, 1, 5'd11, 32'hB00, 0, 5'd0);
      checkOutput("stallReg3", 32'(ctrl_writeReg), 32'd3);
      checkOutput("stallCount", 32'(fifo_count), 32'd2);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd11, 32'hB00, 0, 5'd0);
      checkOutput("retireR9", 32'(ctrl_writeReg), 32'd9);
      checkOutput("retireR9Data", data_writeReg, 32'h900);
      checkOutput("retireR9Count", 32'(fifo_count), 32'd1);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd11, 32'hB00, 0, 5'd0);
      checkOutput("retireR10", 32'(ctrl_writeReg), 32'd10);
      checkOutput("retireR10Count", 32'(fifo_count), 32'd1);
      idle();
      checkOutput("retireR11", 32'(ctrl_writeReg), 32'd11);
      checkOutput("retireR11Data", data_writeReg, 32'hB00);
      checkOutput("drainCount", 32'(fifo_count), 32'd0);

      // Register 0 from the ALU and from mult/div
      applyStimulus(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0);
      checkOutput("aluR0We", 32'(ctrl_writeEnable), 32'd0);
      checkOutput("aluR0Data", data_writeReg, 32'h1234);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd0, 32'h5678, 0, 5'd0);
      checkOutput("mdR0We", 32'(ctrl_writeEnable), 32'd0);
      checkOutput("mdR0Data", data_writeReg, 32'h5678);
      checkOutput("mdR0Count", 32'(fifo_count), 32'd0);

      // Set wins over clear on r12
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd12, 32'hC0, 1, 5'd12);
      checkOutput("r12We", 32'(ctrl_writeEnable), 32'd1);
      checkOutput("r12Reg", 32'(ctrl_writeReg), 32'd12);
      checkOutput("pend12Kept", 32'(pending_mask[12]), 32'd1);

      // Fill the FIFO with pending work, then reset asynchronously mid-cycle
      applyStimulus(1, 5'd4, 32'h44, 1, 5'd20, 32'h2000, 1, 5'd20);
      applyStimulus(1, 5'd6, 32'h66, 1, 5'd21, 32'h2100, 1, 5'd21);
      checkOutput("preResetCount", 32'(fifo_count), 32'd2);
      alu_valid   = 1'b1;
      md_valid    = 1'b0;
      issue_valid = 1'b0;
      #2;
      ctrl_reset = 1'b1;
      #1;
      checkOutput("asyncWe", 32'(ctrl_writeEnable), 32'd0);
      checkOutput("asyncCount", 32'(fifo_count), 32'd0);
      checkOutput("asyncMask", pending_mask, 32'd0);
      checkOutput("asyncReady", 32'(md_ready), 32'd1);
      @(negedge clock);
      ctrl_reset = 1'b0;
      idle();
      idle();
      checkOutput("postResetWe", 32'(ctrl_writeEnable), 32'd0);
      checkOutput("postResetCount", 32'(fifo_count), 32'd0);

      started = 0;
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
